qpsk_mod: RTL
=============

Name: qpsk_mod

Overview:
- QPSK mapper on the transmit side of the OFDM chain.
- Takes a serial bit stream, packs each bit pair into a symbol and maps it to signed I/Q (±1).
- Emits symbols in frames of N_SC subcarriers with start/end markers for the IFFT.
- Uses the same constellation as the receive-side demapper, so a loopback through IFFT/FFT recovers the original bit pairs.

Parameters:
- N_SC, 64, subcarriers per frame (symbols between out_sop and out_eop); ≥2.
- FIFO_DEPTH, 4, symbol FIFO entries; power of two, ≥2.
- W, 16, I/Q output width (signed).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in valid.
- bit_ready  out  1  block accepts bit_in this cycle.
- flush  in  1  single-cycle request to close the current frame.
- out_x  out  W  in-phase value, signed.
- out_y  out  W  quadrature value, signed.
- out_valid  out  1  symbol valid.
- out_ready  in  1  IFFT accepts symbol.
- out_sop  out  1  first subcarrier of frame; qualified by out_valid.
- out_eop  out  1  last subcarrier of frame; qualified by out_valid.
- busy  out  1  flush sequence in progress.

Behaviour:
- Reset (reset=0, async) clears the following; any partial frame and FIFO contents are discarded:
  - half register, FIFO pointers and sc_cnt;
  - state=RUN;
  - out_valid=0, bit_ready=0, busy=0, out_x=out_y=0, out_sop=out_eop=0.
- Bit transfer: bit_valid && bit_ready at a rising edge.
  - First bit of a pair → half register (becomes symbol MSB).
  - Second bit → LSB; {MSB,LSB} is pushed into the FIFO in the same edge.
- bit_ready = (state==RUN) && (!half_valid || !fifo_full).
  - Uses registered full only; no combinational path from out_ready.
- Mapping (W-bit signed, +1 = 1, −1 = all ones):
  - 00→(+1,+1)
  - 01→(−1,+1)
  - 10→(−1,−1)
  - 11→(+1,−1)
  - Mapping is applied at FIFO output; the FIFO stores 2-bit symbols.
- Latency: second bit accepted at edge t → out_valid=1 after edge t (next cycle) when FIFO was empty.
- Output handshake:
  - out_valid = !fifo_empty, or state==PAD.
  - Pop on out_valid && out_ready.
  - out_x, out_y, out_sop, out_eop hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Frame counter sc_cnt (0..N_SC−1):
  - Increments on each output transfer; wraps to 0 after N_SC−1.
  - out_sop = out_valid && sc_cnt==0.
  - out_eop = out_valid && sc_cnt==N_SC−1.
- Flush FSM; flush is sampled only in RUN and ignored elsewhere.
  - RUN: on flush, if half_valid or FIFO non-empty or sc_cnt≠0 → FLUSH_BIT; otherwise no-op.
  - FLUSH_BIT: if half_valid, push {MSB,0} when !fifo_full, then → DRAIN; if no half bit, → DRAIN immediately.
  - DRAIN: wait for fifo_empty. If sc_cnt==0 (frame completed exactly) → RUN, else → PAD.
  - PAD: out_valid=1 with symbol 00 (+1,+1); on the eop transfer → RUN.
- busy = (state≠RUN); bit_ready=0 whenever busy.
- flush coincident with a bit transfer: the bit is accepted first, then the flush sequence includes it.
- Back-pressure: out_ready=0 indefinitely → FIFO fills, bit_ready falls. No bit is lost or duplicated.

Test Plan:
- Reset then bits 0,0,0,1,1,0,1,1 with out_ready=1 → four symbols (1,1),(−1,1),(−1,−1),(1,−1). First out_valid one cycle after the 2nd bit. out_sop on the first symbol.
- 2·N_SC random bits, out_ready=1 → exactly N_SC symbols. out_sop on #0, out_eop on #N_SC−1, sc_cnt back to 0. Demapper loopback recovers all bit pairs.
- out_ready=0 while streaming → after FIFO_DEPTH symbols plus one half bit, bit_ready=0. Outputs stable. Releasing out_ready drains in order with no loss.
- 5 bits then flush → symbols {b0b1},{b2b3},{b4,0}, followed by N_SC−3 padding symbols (+1,+1). out_eop on the last. busy high throughout; bit_ready=0 while busy.
- Flush at an exact frame boundary (sc_cnt=0, FIFO empty, no half bit) → no output, busy stays 0.
- reset pulled low mid-frame with out_valid=1 → out_valid, bit_ready and busy go 0 immediately (asynchronous). After release, the next symbol carries out_sop.

Source files
------------

// File: rtl/qpsk_mod_if.sv
// rtl/qpsk_mod_if.sv - bit-stream input and I/Q symbol output bundle for the QPSK mapper
interface qpsk_mod_if #(
    parameter int W = 16
);
    logic                bit_in;
    logic                bit_valid;
    logic                bit_ready;
    logic                flush;
    logic signed [W-1:0] out_x;
    logic signed [W-1:0] out_y;
    logic                out_valid;
    logic                out_ready;
    logic                out_sop;
    logic                out_eop;
    logic                busy;

    // Mapper side: consumes bits, produces symbols
    modport slave (
        input  bit_in, bit_valid, flush, out_ready,
        output bit_ready, out_x, out_y, out_valid, out_sop, out_eop, busy
    );

    // Environment side: supplies bits, takes symbols
    modport master (
        output bit_in, bit_valid, flush, out_ready,
        input  bit_ready, out_x, out_y, out_valid, out_sop, out_eop, busy
    );
endinterface

// File: rtl/qpsk_mod.sv
// rtl/qpsk_mod.sv - serial bit to QPSK I/Q mapper with symbol FIFO and framed output
module qpsk_mod #(
    parameter int N_SC       = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    qpsk_mod_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(N_SC);

    localparam logic signed [W-1:0] POS_ONE = W'(1);
    localparam logic signed [W-1:0] NEG_ONE = '1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH_BIT = 2'd1,
        DRAIN     = 2'd2,
        PAD       = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          half_valid;
    logic          half_bit;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] sc_cnt;
    logic [1:0]    head_sym;

    logic          fifo_empty;
    logic          fifo_full;
    logic          bit_fire;
    logic          out_fire;
    logic          pad_push;
    logic          push;
    logic          pop;
    logic [1:0]    push_data;
    logic          frame_last;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bit_fire   = bus.bit_valid && bus.bit_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;
    // A dangling half bit is completed with a zero LSB while closing a frame
    assign pad_push   = (state == FLUSH_BIT) && half_valid && !fifo_full;
    assign push       = (bit_fire && half_valid) || pad_push;
    assign push_data  = pad_push ? {half_bit, 1'b0} : {half_bit, bus.bit_in};
    assign pop        = out_fire && !fifo_empty;
    assign frame_last = (sc_cnt == CW'(N_SC - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state logic for the frame-closing sequence
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       if (bus.flush && (half_valid || bit_fire || !fifo_empty || sc_cnt != '0))
                           state_nxt = FLUSH_BIT;
            FLUSH_BIT: if (!half_valid || !fifo_full)
                           state_nxt = DRAIN;
            DRAIN:     if (fifo_empty)
                           state_nxt = (sc_cnt == '0) ? RUN : PAD;
            PAD:       if (out_fire && frame_last)
                           state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
    end

    // Handshakes, busy flag and symbol-to-constellation mapping at the FIFO head
    always_comb begin
        bus.busy      = (state != RUN);
        bus.bit_ready = reset && (state == RUN) && (!half_valid || !fifo_full);
        bus.out_valid = !fifo_empty || (state == PAD);
        head_sym      = fifo_empty ? 2'b00 : mem[rd_ptr[AW-1:0]];
        bus.out_x     = '0;
        bus.out_y     = '0;
        if (bus.out_valid) begin
            bus.out_x = (head_sym[1] == head_sym[0]) ? POS_ONE : NEG_ONE;
            bus.out_y = head_sym[1] ? NEG_ONE : POS_ONE;
        end
        bus.out_sop   = bus.out_valid && (sc_cnt == '0);
        bus.out_eop   = bus.out_valid && frame_last;
    end

    // Half register holds the MSB until its partner bit arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_valid <= 1'b0;
            half_bit   <= 1'b0;
        end else if (bit_fire) begin
            if (!half_valid) begin
                half_bit   <= bus.bit_in;
                half_valid <= 1'b1;
            end else begin
                half_valid <= 1'b0;
            end
        end else if (pad_push) begin
            half_valid <= 1'b0;
        end
    end

    // Symbol storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // FIFO pointers with an extra wrap bit to separate full from empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Subcarrier position within the frame, advanced on every output transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        sc_cnt <= '0;
        else if (out_fire) sc_cnt <= frame_last ? '0 : sc_cnt + CW'(1);
    end
endmodule
